// File: rtl/my_pulse_stretch_if.sv
// Trigger/pulse signal bundle for my_pulse_stretch.
// master drives the trigger side; slave (the stretcher) drives the pulse outputs.
interface my_pulse_stretch_if #(
    parameter int unsigned cnt_width = 8
);
    logic                 d_in;
    logic [cnt_width-1:0] len_in;
    logic                 q_out;
    logic                 busy_out;
    logic                 done_out;

    modport master (
        output d_in,
        output len_in,
        input  q_out,
        input  busy_out,
        input  done_out
    );

    modport slave (
        input  d_in,
        input  len_in,
        output q_out,
        output busy_out,
        output done_out
    );
endinterface

// File: rtl/my_pulse_stretch.sv
// Pulse stretcher: a sampled trigger yields a q_out pulse len_in cycles wide, then a hold-off window.
// Optional macro PULSE_STRETCH_RETRIGGER_EN lets triggers during the pulse reload the width counter.
module my_pulse_stretch #(
    parameter int unsigned cnt_width      = 8,
    parameter int unsigned holdoff_length = 2,
    parameter int unsigned hold_width     = 8
) (
    input  logic                   clk_in,
    input  logic                   clr_in,
    my_pulse_stretch_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam logic [hold_width-1:0] HOLD_INIT =
        (holdoff_length == 0) ? '0 : hold_width'(holdoff_length - 1);

    state_e                state_q;
    logic [cnt_width-1:0]  cnt_q;
    logic [hold_width-1:0] hold_q;
    logic                  q_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  trig_ok;
    logic                  reload;
    logic [cnt_width-1:0]  len_m1;

    assign trig_ok = bus.d_in && (bus.len_in != '0);
    assign len_m1  = bus.len_in - cnt_width'(1);

`ifdef PULSE_STRETCH_RETRIGGER_EN
    assign reload = trig_ok;
`else
    assign reload = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (clr_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (trig_ok) begin
                        state_q <= ACTIVE;
                        cnt_q   <= len_m1;
                        q_q     <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        q_q    <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end

                ACTIVE: begin
                    // A reload keeps q_out high and suppresses the end-of-pulse strobe.
                    if (reload) begin
                        cnt_q  <= len_m1;
                        q_q    <= 1'b1;
                        done_q <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q  <= cnt_q - cnt_width'(1);
                        q_q    <= 1'b1;
                        done_q <= 1'b0;
                    end else begin
                        q_q    <= 1'b0;
                        done_q <= 1'b1;
                        if (holdoff_length == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= HOLDOFF;
                            hold_q  <= HOLD_INIT;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                HOLDOFF: begin
                    q_q    <= 1'b0;
                    done_q <= 1'b0;
                    if (hold_q != '0) begin
                        hold_q <= hold_q - hold_width'(1);
                        busy_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    hold_q  <= '0;
                    q_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q_out    = q_q;
    assign bus.busy_out = busy_q;
    assign bus.done_out = done_q;

    // Output relationships that hold in every state.
    a_q_implies_busy: assert property (@(posedge clk_in) q_q |-> busy_q);
    a_done_not_q:     assert property (@(posedge clk_in) done_q |-> !q_q);
    a_done_single:    assert property (@(posedge clk_in) done_q |=> !done_q);

endmodule
